shot_controller: RTL and testbench
==================================

SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 The block SHALL have parameter ROTATE_FRAMES, default 4: frames per aim step while a rotate key is held.
REQ-002 The block SHALL have parameter CHARGE_FRAMES, default 6: frames per power increment while charging.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetN  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port startOfFrame  input  1  one-cycle pulse per video frame.
REQ-006 The block SHALL have port drawLine  input  1  shot permitted (balls stopped), driven by the game controller.
REQ-007 The block SHALL have ports rotateLeftKey, rotateRightKey, fireKey  input  1 each  level, synchronised key states, 1 = pressed.
REQ-008 The block SHALL have port lineWriteEnable  output  1  one-cycle shot strobe to the ball and game controller.
REQ-009 The block SHALL have ports shotSpeedX, shotSpeedY  output  11 each  signed launch velocity, valid while lineWriteEnable=1 and held afterwards.
REQ-010 The block SHALL have port angleIdx  output  5  aim direction index 0..31, for the aim-line renderer.
REQ-011 The block SHALL have port power  output  4  current charge 0..15, for the power-bar renderer.
REQ-012 The block SHALL have port charging  output  1  high in CHARGE state.

Function
REQ-013 The FSM SHALL have states IDLE, AIM, CHARGE, FIRE, WAIT.
REQ-014 IDLE->AIM SHALL occur when drawLine=1 and fireKey=0; a fire key held on entry SHALL be ignored until released.
REQ-015 In AIM, the block SHALL count startOfFrame pulses while exactly one rotate key is held; on reaching ROTATE_FRAMES it SHALL step angleIdx (+1 left, -1 right, mod 32) and clear the count; the count SHALL clear when neither or both keys are held.
REQ-016 AIM->CHARGE SHALL occur on a fireKey 0->1 transition; power and frame count SHALL clear to 0 on entry.
REQ-017 In CHARGE, power SHALL increment every CHARGE_FRAMES startOfFrame pulses and saturate at 15; angleIdx SHALL be frozen.
REQ-018 CHARGE->FIRE SHALL occur on fireKey=0; in the same edge shotSpeedX/Y SHALL latch (dirX*(power+1))>>>2 and (dirY*(power+1))>>>2, arithmetic shift (round toward minus infinity).
REQ-019 dirX = round(64*cos(2*pi*angleIdx/32)), dirY = -round(64*sin(2*pi*angleIdx/32)), signed in -64..64 (screen y grows downward).
REQ-020 FIRE SHALL last exactly one cycle, with lineWriteEnable=1 only in that cycle, then go to WAIT.
REQ-021 WAIT->IDLE SHALL occur when drawLine=0 or after 2 startOfFrame pulses, whichever comes first, so that a zero-motion shot cannot lock the FSM.
REQ-022 drawLine=0 in AIM or CHARGE SHALL return the FSM to IDLE with no strobe, power cleared, and angleIdx retained.
REQ-023 Outside CHARGE, power SHALL hold its last value until the next CHARGE entry.

Reset
REQ-024 resetN=0 SHALL asynchronously force: state IDLE, lineWriteEnable 0, shotSpeedX/Y 0, angleIdx 0, power 0, charging 0, all frame counters 0.
REQ-025 Reset mid-CHARGE SHALL produce no strobe; after release the FSM SHALL require a fresh fireKey release/press sequence.

Structure
REQ-026 Package shot_pkg SHALL hold the state enum, the SPEED_W=11 and ANGLE_W=5 constants and the power maximum (15).
REQ-027 Sub-module direction_lut SHALL be a combinational 32-entry ROM mapping angleIdx to signed 8-bit dirX/dirY.
REQ-028 The multiply SHALL be 8b x 5b signed, with the result sign-extended to 11 bits before the shift.

Verification
REQ-029 Reset, drawLine=1, idx 0, press fire and release before any frame -> one strobe, shotSpeedX=16, shotSpeedY=0, power=0.
REQ-030 Hold fire for 100 frames with idx 8, then release -> power saturates at 15, strobe with shotSpeedX=0 and shotSpeedY=-256.
REQ-031 rotateRightKey held for 4 frames from idx 0 -> angleIdx=31; both keys held for 8 frames -> angleIdx unchanged.
REQ-032 drawLine drops during CHARGE -> no strobe, state IDLE; next press and release with drawLine=1 -> exactly one strobe.
REQ-033 fireKey held when drawLine rises -> no CHARGE until fireKey is released and pressed again.
REQ-034 After a strobe with drawLine held at 1 -> WAIT exits to IDLE after 2 frames; exactly one strobe per press.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared types and constants for the cue-shot controller.
package shot_pkg;

    localparam int SPEED_W = 11;
    localparam int ANGLE_W = 5;
    localparam int POWER_W = 4;
    localparam int DIR_W   = 8;

    localparam logic [POWER_W-1:0] POWER_MAX = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        CHARGE,
        FIRE,
        WAIT
    } state_e;

endpackage

// File: rtl/direction_lut.sv
// Combinational 32-entry direction ROM: unit vector scaled by 64 for each aim index.
// Screen y grows downward, so dir_y is the negated sine.
module direction_lut
    import shot_pkg::*;
(
    input  logic [ANGLE_W-1:0]      angle_idx,
    output logic signed [DIR_W-1:0] dir_x,
    output logic signed [DIR_W-1:0] dir_y
);

    // round(64*cos(2*pi*idx/32)); sine is the same table shifted by a quarter turn.
    function automatic logic signed [DIR_W-1:0] cos64(input logic [ANGLE_W-1:0] idx);
        case (idx)
            5'd0:  cos64 =  8'sd64;
            5'd1:  cos64 =  8'sd63;
            5'd2:  cos64 =  8'sd59;
            5'd3:  cos64 =  8'sd53;
            5'd4:  cos64 =  8'sd45;
            5'd5:  cos64 =  8'sd36;
            5'd6:  cos64 =  8'sd24;
            5'd7:  cos64 =  8'sd12;
            5'd8:  cos64 =  8'sd0;
            5'd9:  cos64 = -8'sd12;
            5'd10: cos64 = -8'sd24;
            5'd11: cos64 = -8'sd36;
            5'd12: cos64 = -8'sd45;
            5'd13: cos64 = -8'sd53;
            5'd14: cos64 = -8'sd59;
            5'd15: cos64 = -8'sd63;
            5'd16: cos64 = -8'sd64;
            5'd17: cos64 = -8'sd63;
            5'd18: cos64 = -8'sd59;
            5'd19: cos64 = -8'sd53;
            5'd20: cos64 = -8'sd45;
            5'd21: cos64 = -8'sd36;
            5'd22: cos64 = -8'sd24;
            5'd23: cos64 = -8'sd12;
            5'd24: cos64 =  8'sd0;
            5'd25: cos64 =  8'sd12;
            5'd26: cos64 =  8'sd24;
            5'd27: cos64 =  8'sd36;
            5'd28: cos64 =  8'sd45;
            5'd29: cos64 =  8'sd53;
            5'd30: cos64 =  8'sd59;
            default: cos64 = 8'sd63;
        endcase
    endfunction

    logic [ANGLE_W-1:0] sin_idx;

    // sin(a) = cos(a - quarter turn); index arithmetic wraps mod 32.
    always_comb begin
        sin_idx = angle_idx - 5'd8;
        dir_x   = cos64(angle_idx);
        dir_y   = -cos64(sin_idx);
    end

endmodule

// File: rtl/shot_controller.sv
// Cue-shot controller: aim rotation, power charge and a one-cycle launch strobe
// carrying the signed launch velocity to the ball and game controllers.
module shot_controller
    import shot_pkg::*;
#(
    parameter int ROTATE_FRAMES = 4,
    parameter int CHARGE_FRAMES = 6
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               drawLine,
    input  logic               rotateLeftKey,
    input  logic               rotateRightKey,
    input  logic               fireKey,
    output logic               lineWriteEnable,
    output logic [SPEED_W-1:0] shotSpeedX,
    output logic [SPEED_W-1:0] shotSpeedY,
    output logic [ANGLE_W-1:0] angleIdx,
    output logic [POWER_W-1:0] power,
    output logic               charging
);

    localparam int ROT_CW  = $clog2(ROTATE_FRAMES + 1);
    localparam int CHG_CW  = $clog2(CHARGE_FRAMES + 1);
    localparam logic [ROT_CW-1:0] ROT_LAST = ROT_CW'(ROTATE_FRAMES - 1);
    localparam logic [CHG_CW-1:0] CHG_LAST = CHG_CW'(CHARGE_FRAMES - 1);

    state_e             state_q,     state_d;
    logic [ANGLE_W-1:0] angle_q,     angle_d;
    logic [POWER_W-1:0] power_q,     power_d;
    logic [ROT_CW-1:0]  rot_cnt_q,   rot_cnt_d;
    logic [CHG_CW-1:0]  chg_cnt_q,   chg_cnt_d;
    logic               wait_cnt_q,  wait_cnt_d;
    logic               fire_prev_q, fire_prev_d;
    logic [SPEED_W-1:0] speed_x_q,   speed_x_d;
    logic [SPEED_W-1:0] speed_y_q,   speed_y_d;
    logic               lwe_q,       lwe_d;
    logic               charging_q,  charging_d;

    logic signed [DIR_W-1:0] dir_x, dir_y;
    logic [4:0]              power_mul;
    logic signed [12:0]      prod_x, prod_y;
    logic [SPEED_W-1:0]      shot_x, shot_y;

    direction_lut u_direction_lut (
        .angle_idx (angle_q),
        .dir_x     (dir_x),
        .dir_y     (dir_y)
    );

    // Launch velocity from the current aim and charge: (dir * (power+1)) >>> 2.
    // The product is kept 13 bits wide so +64*16 = +1024 stays positive before
    // the shift; every shifted result fits comfortably in SPEED_W bits.
    always_comb begin
        power_mul = {1'b0, power_q} + 5'd1;
        prod_x    = $signed({{5{dir_x[DIR_W-1]}}, dir_x}) * $signed({8'd0, power_mul});
        prod_y    = $signed({{5{dir_y[DIR_W-1]}}, dir_y}) * $signed({8'd0, power_mul});
        shot_x    = SPEED_W'(prod_x >>> 2);
        shot_y    = SPEED_W'(prod_y >>> 2);
    end

    // Next-state logic for the shot FSM, its counters and registered outputs.
    always_comb begin
        // NOTE: every _d starts from its _q (or a safe default) so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        angle_d     = angle_q;
        power_d     = power_q;
        rot_cnt_d   = '0;
        chg_cnt_d   = chg_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        speed_x_d   = speed_x_q;
        speed_y_d   = speed_y_q;
        fire_prev_d = fireKey;

        case (state_q)
            IDLE: begin
                // A fire key already down must be released before aiming starts.
                if (drawLine && !fireKey) state_d = AIM;
            end

            AIM: begin
                if (!drawLine) begin
                    state_d = IDLE;
                    power_d = '0;
                end else if (fireKey && !fire_prev_q) begin
                    state_d   = CHARGE;
                    power_d   = '0;
                    chg_cnt_d = '0;
                end else if (rotateLeftKey ^ rotateRightKey) begin
                    rot_cnt_d = rot_cnt_q;
                    if (startOfFrame) begin
                        if (rot_cnt_q == ROT_LAST) begin
                            rot_cnt_d = '0;
                            angle_d   = rotateLeftKey ? angle_q + 5'd1 : angle_q - 5'd1;
                        end else begin
                            rot_cnt_d = rot_cnt_q + 1'b1;
                        end
                    end
                end
            end

            CHARGE: begin
                if (!drawLine) begin
                    state_d = IDLE;
                    power_d = '0;
                end else if (!fireKey) begin
                    state_d   = FIRE;
                    speed_x_d = shot_x;
                    speed_y_d = shot_y;
                end else if (startOfFrame) begin
                    if (chg_cnt_q == CHG_LAST) begin
                        chg_cnt_d = '0;
                        if (power_q != POWER_MAX) power_d = power_q + 1'b1;
                    end else begin
                        chg_cnt_d = chg_cnt_q + 1'b1;
                    end
                end
            end

            FIRE: begin
                state_d    = WAIT;
                wait_cnt_d = 1'b0;
            end

            WAIT: begin
                // Timeout guards against a shot too weak to ever move the balls.
                if (!drawLine) begin
                    state_d = IDLE;
                end else if (startOfFrame) begin
                    if (wait_cnt_q) state_d = IDLE;
                    else            wait_cnt_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        lwe_d      = (state_d == FIRE);
        charging_d = (state_d == CHARGE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            angle_q     <= '0;
            power_q     <= '0;
            rot_cnt_q   <= '0;
            chg_cnt_q   <= '0;
            wait_cnt_q  <= 1'b0;
            fire_prev_q <= 1'b0;
            speed_x_q   <= '0;
            speed_y_q   <= '0;
            lwe_q       <= 1'b0;
            charging_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            angle_q     <= angle_d;
            power_q     <= power_d;
            rot_cnt_q   <= rot_cnt_d;
            chg_cnt_q   <= chg_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fire_prev_q <= fire_prev_d;
            speed_x_q   <= speed_x_d;
            speed_y_q   <= speed_y_d;
            lwe_q       <= lwe_d;
            charging_q  <= charging_d;
        end
    end

    assign lineWriteEnable = lwe_q;
    assign shotSpeedX      = speed_x_q;
    assign shotSpeedY      = speed_y_q;
    assign angleIdx        = angle_q;
    assign power           = power_q;
    assign charging        = charging_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: inputs change on the falling edge,
// outputs are compared on the falling edge, strobes counted on the rising edge.
module tb_shot_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        drawLine;
    logic        rotateLeftKey;
    logic        rotateRightKey;
    logic        fireKey;
    logic        lineWriteEnable;
    logic [10:0] shotSpeedX;
    logic [10:0] shotSpeedY;
    logic [4:0]  angleIdx;
    logic [3:0]  power;
    logic        charging;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;

    shot_controller #(
        .ROTATE_FRAMES (4),
        .CHARGE_FRAMES (6)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .drawLine        (drawLine),
        .rotateLeftKey   (rotateLeftKey),
        .rotateRightKey  (rotateRightKey),
        .fireKey         (fireKey),
        .lineWriteEnable (lineWriteEnable),
        .shotSpeedX      (shotSpeedX),
        .shotSpeedY      (shotSpeedY),
        .angleIdx        (angleIdx),
        .power           (power),
        .charging        (charging)
    );

    always #5 clk = ~clk;

    // Each rising edge that sees the strobe high counts one shot.
    always @(posedge clk) begin
        if (lineWriteEnable === 1'b1) strobes++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One startOfFrame pulse followed by one quiet cycle.
    task automatic sof(input int n = 1);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    function automatic int sx();
        return int'($signed(shotSpeedX));
    endfunction

    function automatic int sy();
        return int'($signed(shotSpeedY));
    endfunction

    initial begin
        resetN         = 1'b0;
        startOfFrame   = 1'b0;
        drawLine       = 1'b0;
        rotateLeftKey  = 1'b0;
        rotateRightKey = 1'b0;
        fireKey        = 1'b0;
        tick(2);
        check("rst_lwe",      int'(lineWriteEnable), 0);
        check("rst_speed_x",  sx(), 0);
        check("rst_speed_y",  sy(), 0);
        check("rst_angle",    int'(angleIdx), 0);
        check("rst_power",    int'(power), 0);
        check("rst_charging", int'(charging), 0);
        resetN = 1'b1;
        tick();

        // Quick tap at idx 0, power 0: 64*1>>>2 = 16.
        drawLine = 1'b1;
        tick();
        fireKey = 1'b1;
        tick();
        check("tap_charging", int'(charging), 1);
        check("tap_power",    int'(power), 0);
        fireKey = 1'b0;
        tick();
        check("tap_lwe",      int'(lineWriteEnable), 1);
        check("tap_speed_x",  sx(), 16);
        check("tap_speed_y",  sy(), 0);
        check("tap_charging_off", int'(charging), 0);
        tick();
        check("tap_lwe_one_cycle", int'(lineWriteEnable), 0);
        check("tap_strobes",  strobes, 1);

        // WAIT holds through one frame, exits after the second with drawLine high.
        sof(1);
        fireKey = 1'b1;
        tick(2);
        check("wait_hold", int'(charging), 0);
        fireKey = 1'b0;
        tick();
        sof(1);
        fireKey = 1'b1;
        tick();
        check("wait_exit", int'(charging), 1);
        fireKey = 1'b0;
        tick();
        check("wait_shot_lwe", int'(lineWriteEnable), 1);
        tick();
        check("wait_strobes", strobes, 2);
        drawLine = 1'b0;
        tick();

        // Rotation: right steps after exactly 4 frames, both keys freeze.
        drawLine = 1'b1;
        tick();
        rotateRightKey = 1'b1;
        sof(3);
        check("rot_3_frames", int'(angleIdx), 0);
        sof(1);
        check("rot_right_wrap", int'(angleIdx), 31);
        rotateLeftKey = 1'b1;
        sof(8);
        check("rot_both_keys", int'(angleIdx), 31);
        rotateRightKey = 1'b0;
        sof(4);
        check("rot_left_wrap", int'(angleIdx), 0);
        sof(32);
        check("rot_left_to_8", int'(angleIdx), 8);

        // Long charge at idx 8 with left key still held: power saturates, aim frozen.
        fireKey = 1'b1;
        tick();
        check("chg_charging", int'(charging), 1);
        sof(5);
        check("chg_5_frames", int'(power), 0);
        sof(1);
        check("chg_6_frames", int'(power), 1);
        sof(94);
        check("chg_saturate", int'(power), 15);
        check("chg_angle_frozen", int'(angleIdx), 8);
        fireKey = 1'b0;
        tick();
        check("chg_lwe",     int'(lineWriteEnable), 1);
        check("chg_speed_x", sx(), 0);
        check("chg_speed_y", sy(), -256);
        rotateLeftKey = 1'b0;
        tick();
        check("chg_power_hold", int'(power), 15);
        check("chg_strobes", strobes, 3);
        drawLine = 1'b0;
        tick();

        // drawLine drops mid-charge: no strobe, power cleared, aim kept.
        drawLine = 1'b1;
        tick();
        fireKey = 1'b1;
        tick();
        sof(7);
        check("abort_power_before", int'(power), 1);
        drawLine = 1'b0;
        tick();
        check("abort_charging", int'(charging), 0);
        check("abort_power",    int'(power), 0);
        check("abort_angle",    int'(angleIdx), 8);
        fireKey = 1'b0;
        tick(3);
        check("abort_no_strobe", strobes, 3);
        drawLine = 1'b1;
        tick();
        fireKey = 1'b1;
        tick();
        fireKey = 1'b0;
        tick();
        check("abort_retry_lwe", int'(lineWriteEnable), 1);
        check("abort_retry_x",   sx(), 0);
        check("abort_retry_y",   sy(), -16);
        tick();
        check("abort_retry_strobes", strobes, 4);
        drawLine = 1'b0;
        tick();

        // Fire held while drawLine rises: ignored until released and pressed again.
        fireKey = 1'b1;
        tick();
        drawLine = 1'b1;
        sof(3);
        check("held_fire_idle", int'(charging), 0);
        fireKey = 1'b0;
        tick(2);
        check("held_fire_released", int'(charging), 0);
        fireKey = 1'b1;
        tick();
        check("held_fire_repress", int'(charging), 1);
        fireKey = 1'b0;
        tick();
        check("held_fire_lwe", int'(lineWriteEnable), 1);
        tick();
        check("held_fire_strobes", strobes, 5);
        drawLine = 1'b0;
        tick();

        // Reset mid-charge: no strobe, fresh release/press needed afterwards.
        drawLine = 1'b1;
        tick();
        fireKey = 1'b1;
        tick();
        check("rst_mid_charging", int'(charging), 1);
        sof(7);
        resetN = 1'b0;
        #1;
        check("rst_mid_charging_off", int'(charging), 0);
        check("rst_mid_power",   int'(power), 0);
        check("rst_mid_angle",   int'(angleIdx), 0);
        check("rst_mid_speed_y", sy(), 0);
        check("rst_mid_lwe",     int'(lineWriteEnable), 0);
        tick();
        resetN = 1'b1;
        tick(3);
        check("rst_mid_held", int'(charging), 0);
        fireKey = 1'b0;
        tick(2);
        check("rst_mid_no_strobe", strobes, 5);
        fireKey = 1'b1;
        tick();
        fireKey = 1'b0;
        tick();
        check("rst_mid_lwe_after", int'(lineWriteEnable), 1);
        check("rst_mid_speed_x",   sx(), 16);
        tick();
        check("rst_mid_strobes", strobes, 6);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
